// File: rtl/bcd_converter_seq_if.sv
// ----------------------------------------------------------------------------
// bcd_converter_seq_if
//  Request/response bundle for the sequential binary-to-BCD converter.
//  Ports (via modports):
//   start       master->slave  request a conversion (taken only while busy==0)
//   binary      master->slave  unsigned value to convert, WIDTH bits
//   busy        slave->master  conversion in progress
//   done        slave->master  one-cycle pulse, results updated
//   bcd         slave->master  4*DIGITS result, digit i at [4i+3:4i]
//   blank_mask  slave->master  bit i set when digit i and all above are zero
//   overflow    slave->master  value exceeded 10^DIGITS-1
// ----------------------------------------------------------------------------
interface bcd_converter_seq_if #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
);
    logic                  start;
    logic [WIDTH-1:0]      binary;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd;
    logic [DIGITS-1:0]     blank_mask;
    logic                  overflow;

    modport master (
        output start,
        output binary,
        input  busy,
        input  done,
        input  bcd,
        input  blank_mask,
        input  overflow
    );

    modport slave (
        input  start,
        input  binary,
        output busy,
        output done,
        output bcd,
        output blank_mask,
        output overflow
    );
endinterface

// File: rtl/bcd_converter_seq.sv
// ----------------------------------------------------------------------------
// bcd_converter_seq
//  Sequential binary-to-BCD converter (shift-and-add-3), one input bit per
//  clock. Accepts a value on start while idle, produces the BCD digits, a
//  leading-zero blank mask and an overflow flag WIDTH+1 edges later with a
//  one-cycle done pulse. Result outputs only change on completion.
//  Ports:
//   clk    in  rising-edge clock
//   reset  in  asynchronous, active-high reset
//   bus    slave modport of bcd_converter_seq_if (start/binary in,
//          busy/done/bcd/blank_mask/overflow out)
// ----------------------------------------------------------------------------
module bcd_converter_seq #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
) (
    input  logic               clk,
    input  logic               reset,
    bcd_converter_seq_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t                state_r;
    logic [WIDTH-1:0]      shift_r;
    logic [4*DIGITS-1:0]   scratch_r;
    logic                  ovf_r;
    logic [CW-1:0]         cnt_r;
    logic                  busy_r;
    logic                  done_r;
    logic [4*DIGITS-1:0]   bcd_r;
    logic [DIGITS-1:0]     blank_r;
    logic                  overflow_r;

    logic [4*DIGITS-1:0]   adjusted_s;
    logic [4*DIGITS-1:0]   scratch_next_s;
    logic                  carry_out_s;

    // Bit i set when digit i and every digit above it is zero; bit 0 is
    // never set so a value of zero still displays a single "0".
    function automatic logic [DIGITS-1:0] blank_of(input logic [4*DIGITS-1:0] v);
        logic             zero_above;
        logic [DIGITS-1:0] m;
        m          = {DIGITS{1'b0}};
        zero_above = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            zero_above = zero_above & (v[4*i +: 4] == 4'd0);
            m[i]       = zero_above;
        end
        return m;
    endfunction

    // Add-3 correction on every digit >= 5, then the one-bit left shift.
    always_comb begin
        adjusted_s = scratch_r;
        for (int i = 0; i < DIGITS; i++) begin
            if (scratch_r[4*i +: 4] >= 4'd5) begin
                adjusted_s[4*i +: 4] = scratch_r[4*i +: 4] + 4'd3;
            end else begin
                adjusted_s[4*i +: 4] = scratch_r[4*i +: 4];
            end
        end
        // The bit pushed out of the top digit is a carry into a digit we do
        // not have, so the value has exceeded 10^DIGITS-1.
        carry_out_s    = adjusted_s[4*DIGITS-1];
        scratch_next_s = {adjusted_s[4*DIGITS-2:0], shift_r[WIDTH-1]};
    end

    // Control FSM, datapath scratch registers and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= IDLE;
            shift_r    <= {WIDTH{1'b0}};
            scratch_r  <= {(4*DIGITS){1'b0}};
            ovf_r      <= 1'b0;
            cnt_r      <= {CW{1'b0}};
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            bcd_r      <= {(4*DIGITS){1'b0}};
            blank_r    <= {DIGITS{1'b0}};
            overflow_r <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (bus.start) begin
                        shift_r   <= bus.binary;
                        scratch_r <= {(4*DIGITS){1'b0}};
                        ovf_r     <= 1'b0;
                        cnt_r     <= CW'(WIDTH);
                        busy_r    <= 1'b1;
                        state_r   <= SHIFT;
                    end else begin
                        state_r   <= IDLE;
                    end
                end
                SHIFT: begin
                    if (cnt_r != {CW{1'b0}}) begin
                        scratch_r <= scratch_next_s;
                        shift_r   <= shift_r << 1'b1;
                        ovf_r     <= ovf_r | carry_out_s;
                        cnt_r     <= cnt_r - CW'(1);
                    end else begin
                        bcd_r      <= scratch_r;
                        overflow_r <= ovf_r;
                        blank_r    <= blank_of(scratch_r);
                        done_r     <= 1'b1;
                        busy_r     <= 1'b0;
                        state_r    <= IDLE;
                    end
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy       = busy_r;
    assign bus.done       = done_r;
    assign bus.bcd        = bcd_r;
    assign bus.blank_mask = blank_r;
    assign bus.overflow   = overflow_r;

endmodule

// File: tb/tb_bcd_converter_seq.sv
// ----------------------------------------------------------------------------
// tb_bcd_converter_seq
//  Directed bench for bcd_converter_seq: a 16-bit/5-digit and an 8-bit/2-digit
//  instance. Expected results are computed arithmetically when a conversion
//  is launched, queued, and popped when done is seen.
// ----------------------------------------------------------------------------
module tb_bcd_converter_seq;
    localparam int W  = 16;
    localparam int D  = 5;
    localparam int W8 = 8;
    localparam int D8 = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    bcd_converter_seq_if #(.WIDTH(W),  .DIGITS(D))  bus16 ();
    bcd_converter_seq_if #(.WIDTH(W8), .DIGITS(D8)) bus8 ();

    bcd_converter_seq #(.WIDTH(W), .DIGITS(D)) dut16 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus16.slave)
    );

    bcd_converter_seq #(.WIDTH(W8), .DIGITS(D8)) dut8 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus8.slave)
    );

    typedef struct packed {
        logic [31:0] bcd;
        logic [7:0]  blank;
        logic        ovf;
    } exp_t;

    exp_t q16[$];
    exp_t q8[$];
    int compared   = 0;
    int mismatched = 0;

    // Decimal reference: value mod 10^digits, digit by digit.
    function automatic exp_t model(int unsigned v, int digits);
        exp_t        e;
        int unsigned lim;
        int unsigned r;
        bit          zero_above;
        lim = 1;
        for (int i = 0; i < digits; i++) lim = lim * 10;
        e.ovf   = (v >= lim);
        e.bcd   = 32'd0;
        e.blank = 8'd0;
        r = v % lim;
        for (int i = 0; i < digits; i++) begin
            e.bcd[4*i +: 4] = 4'(r % 10);
            r = r / 10;
        end
        zero_above = 1'b1;
        for (int i = digits - 1; i >= 1; i--) begin
            zero_above = zero_above && (e.bcd[4*i +: 4] == 4'd0);
            e.blank[i] = zero_above;
        end
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        compared++;
        assert (obs === exp_v) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic launch16(input int unsigned v, input bit push);
        bus16.binary = W'(v);
        bus16.start  = 1'b1;
        if (push) q16.push_back(model(v, D));
    endtask

    task automatic launch8(input int unsigned v);
        bus8.binary = W8'(v);
        bus8.start  = 1'b1;
        q8.push_back(model(v, D8));
    endtask

    // Called at the negedge where start was driven; returns at the done cycle.
    // A start pulse with inject_val is driven at edge inject_at (0 = none).
    task automatic wait16(input string tag, input int inject_at, input int unsigned inject_val);
        int   edges;
        bit   seen;
        exp_t e;
        edges = 0;
        seen  = 1'b0;
        @(negedge clk);
        bus16.start = 1'b0;
        check({tag, "_busy_after_accept"}, 32'(bus16.busy), 32'd1);
        check({tag, "_done_low_after_accept"}, 32'(bus16.done), 32'd0);
        while (!seen && edges < 40) begin
            @(negedge clk);
            edges++;
            if (bus16.done) seen = 1'b1;
            if (edges == inject_at) begin
                bus16.start  = 1'b1;
                bus16.binary = W'(inject_val);
            end
            if (edges == inject_at + 1) bus16.start = 1'b0;
        end
        check({tag, "_latency"}, 32'(edges), 32'(W + 1));
        check({tag, "_busy_in_done"}, 32'(bus16.busy), 32'd0);
        if (q16.size() > 0) begin
            e = q16.pop_front();
            check({tag, "_bcd"},      32'(bus16.bcd),        e.bcd);
            check({tag, "_blank"},    32'(bus16.blank_mask), 32'(e.blank));
            check({tag, "_overflow"}, 32'(bus16.overflow),   32'(e.ovf));
        end
    endtask

    task automatic wait8(input string tag);
        int   edges;
        bit   seen;
        exp_t e;
        edges = 0;
        seen  = 1'b0;
        @(negedge clk);
        bus8.start = 1'b0;
        check({tag, "_busy_after_accept"}, 32'(bus8.busy), 32'd1);
        while (!seen && edges < 30) begin
            @(negedge clk);
            edges++;
            if (bus8.done) seen = 1'b1;
        end
        check({tag, "_latency"}, 32'(edges), 32'(W8 + 1));
        if (q8.size() > 0) begin
            e = q8.pop_front();
            check({tag, "_bcd"},      32'(bus8.bcd),        e.bcd);
            check({tag, "_blank"},    32'(bus8.blank_mask), 32'(e.blank));
            check({tag, "_overflow"}, 32'(bus8.overflow),   32'(e.ovf));
        end
    endtask

    initial begin
        bit saw_done;
        reset        = 1'b1;
        bus16.start  = 1'b0;
        bus16.binary = 16'd0;
        bus8.start   = 1'b0;
        bus8.binary  = 8'd0;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Reset state and idle hold.
        check("rst_busy",     32'(bus16.busy),       32'd0);
        check("rst_done",     32'(bus16.done),       32'd0);
        check("rst_bcd",      32'(bus16.bcd),        32'd0);
        check("rst_blank",    32'(bus16.blank_mask), 32'd0);
        check("rst_overflow", 32'(bus16.overflow),   32'd0);
        check("rst_bcd8",     32'(bus8.bcd),         32'd0);
        repeat (3) @(negedge clk);
        check("idle_busy", 32'(bus16.busy), 32'd0);
        check("idle_done", 32'(bus16.done), 32'd0);

        // Zero input.
        launch16(0, 1'b1);
        wait16("zero", 0, 0);
        @(negedge clk);
        check("zero_done_one_cycle", 32'(bus16.done), 32'd0);

        // Start while busy is ignored.
        launch16(1234, 1'b1);
        wait16("ignore", 5, 9999);
        @(negedge clk);
        check("ignore_no_queue_busy", 32'(bus16.busy), 32'd0);
        check("ignore_no_queue_done", 32'(bus16.done), 32'd0);

        // Maximum value, then back-to-back start in the done cycle.
        launch16(65535, 1'b1);
        wait16("max", 0, 0);
        check("max_bcd_const", 32'(bus16.bcd), 32'h00065535);
        launch16(42, 1'b1);
        wait16("b2b", 0, 0);
        check("b2b_blank_const", 32'(bus16.blank_mask), 32'h1c);

        // Reset at cycle 8 of a conversion aborts without done.
        launch16(777, 1'b0);
        @(negedge clk);
        bus16.start = 1'b0;
        repeat (7) @(negedge clk);
        reset = 1'b1;
        #1;
        check("abort_busy",  32'(bus16.busy), 32'd0);
        check("abort_bcd",   32'(bus16.bcd),  32'd0);
        check("abort_done",  32'(bus16.done), 32'd0);
        check("abort_blank", 32'(bus16.blank_mask), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        saw_done = 1'b0;
        repeat (25) begin
            @(negedge clk);
            if (bus16.done) saw_done = 1'b1;
        end
        check("abort_no_done", 32'(saw_done), 32'd0);

        // Narrow instance: overflow wraps, then an in-range value.
        launch8(255);
        wait8("w8_255");
        @(negedge clk);
        launch8(99);
        wait8("w8_99");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
